// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory itself.
package imem_pkg;

  localparam int          IMEM_DEPTH     = 128;
  localparam int          IMEM_ADDR_W    = 7;
  localparam logic [31:0] IMEM_FILL_WORD = 32'h0;
  localparam logic [1:0]  LAST_BYTE_IDX  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } imem_state_e;

  // A zero count or anything past the memory end means "load the whole memory".
  function automatic int clampCount(input logic [7:0] wc, input int depth);
    if (wc == 8'd0 || 32'(wc) >= depth) return depth;
    return 32'(wc);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word assembler: the first byte shifted in ends up as the LSB.
module word_assembler
  import imem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [31:0] r_word;
  logic [1:0]  r_bidx;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_word <= '0;
      r_bidx <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_bidx <= '0;
    end else if (i_shift) begin
      r_word <= {i_byte, r_word[31:8]};
      r_bidx <= r_bidx + 2'd1;
    end
  end

  assign o_word       = r_word;
  assign o_word_ready = i_shift && (r_bidx == LAST_BYTE_IDX);

endmodule

// File: rtl/imem_loader.sv
// Loads a program into instruction memory from a byte stream, zero-fills the rest,
// and holds the CPU in reset for the duration.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH   = IMEM_DEPTH,
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              LoadStart,
  input  logic [7:0]        WordCount,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemWA,
  output logic [31:0]       MemWD,
  output logic              CpuHold,
  output logic              LoadBusy,
  output logic              LoadDone,
  output logic              LoadError
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_RECV  = 3'(ST_RECV);
  localparam logic [2:0] S_WRITE = 3'(ST_WRITE);
  localparam logic [2:0] S_FILL  = 3'(ST_FILL);
  localparam logic [2:0] S_DONE  = 3'(ST_DONE);
  localparam logic [2:0] S_ERROR = 3'(ST_ERROR);

  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_widx;
  logic [IDLE_W-1:0] r_idleCnt;

  logic        w_rxReady;
  logic        w_accept;
  logic        w_start;
  logic        w_asmClear;
  logic [31:0] w_word;
  logic        w_wordReady;

  assign w_rxReady  = (r_state == S_RECV);
  assign w_accept   = RxValid && w_rxReady;
  assign w_start    = LoadStart && ((r_state == S_IDLE) || (r_state == S_ERROR));
  assign w_asmClear = w_start || (r_state == S_WRITE);

  word_assembler u_asm (
    .i_clk        (CLK),
    .i_rstn       (RESETn),
    .i_clear      (w_asmClear),
    .i_shift      (w_accept),
    .i_byte       (RxData),
    .o_word       (w_word),
    .o_word_ready (w_wordReady)
  );

  // widx carries one extra bit so a full-depth count never wraps in the last-word compare.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_widx    <= '0;
      r_idleCnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (w_start) begin
            r_state   <= S_RECV;
            r_cnt     <= CNT_W'(clampCount(WordCount, DEPTH));
            r_widx    <= '0;
            r_idleCnt <= '0;
          end
        end
        S_RECV: begin
          if (w_accept) begin
            r_idleCnt <= '0;
            if (w_wordReady) r_state <= S_WRITE;
          end else if (r_idleCnt == IDLE_LAST) begin
            r_state <= S_ERROR;
          end else begin
            r_idleCnt <= r_idleCnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_widx <= r_widx + 1'b1;
          if (r_widx == r_cnt - 1'b1)
            r_state <= (r_cnt < CNT_DEPTH) ? S_FILL : S_DONE;
          else
            r_state <= S_RECV;
        end
        S_FILL: begin
          r_widx <= r_widx + 1'b1;
          if (r_widx == CNT_LAST) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    RxReady   = 1'b0;
    MemWE     = 1'b0;
    MemWA     = '0;
    MemWD     = '0;
    CpuHold   = 1'b0;
    LoadBusy  = 1'b0;
    LoadDone  = 1'b0;
    LoadError = 1'b0;
    case (r_state)
      S_RECV: begin
        RxReady  = 1'b1;
        CpuHold  = 1'b1;
        LoadBusy = 1'b1;
      end
      S_WRITE: begin
        MemWE    = 1'b1;
        MemWA    = r_widx[ADDR_W-1:0];
        MemWD    = w_word;
        CpuHold  = 1'b1;
        LoadBusy = 1'b1;
      end
      S_FILL: begin
        MemWE    = 1'b1;
        MemWA    = r_widx[ADDR_W-1:0];
        MemWD    = IMEM_FILL_WORD;
        CpuHold  = 1'b1;
        LoadBusy = 1'b1;
      end
      S_DONE: begin
        LoadDone = 1'b1;
        CpuHold  = 1'b1;
        LoadBusy = 1'b1;
      end
      // The memory may hold a partial program, so the CPU stays held.
      S_ERROR: begin
        LoadError = 1'b1;
        CpuHold   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
